// File: rtl/amp_meter_pkg.sv
// amp_meter_pkg: gain index codes, mV scale factors, over-range default and FSM state type
package amp_meter_pkg;
  localparam logic [1:0] GAIN_3     = 2'd0;
  localparam logic [1:0] GAIN_6_5   = 2'd1;
  localparam logic [1:0] GAIN_13_5  = 2'd2;
  localparam logic [1:0] GAIN_29_25 = 2'd3;
  localparam int OVER_THRESH_DEF = 3941;
  typedef enum logic [1:0] {IDLE, ACQUIRE, CALC, OUTPUT} state_t;
  // 16-bit fractional code-to-mV factor: round(65536*2000/4095/gain)
  function automatic logic [15:0] k_of(input logic [1:0] g);
    return g == GAIN_3 ? 16'd10669 : g == GAIN_6_5 ? 16'd4924 : g == GAIN_13_5 ? 16'd2371 : 16'd1094;
  endfunction
endpackage

// File: rtl/amplitude_meter_if.sv
// amplitude_meter_if: ADC stream and gain status in, measurement results out; dc_code exists only with AMP_METER_DC_EN
interface amplitude_meter_if;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [1:0]  gain_idx;
  logic        gain_stable;
  logic        meas_valid;
  logic [11:0] vpp_code;
  logic [11:0] vin_mv;
  logic [1:0]  meas_gain;
  logic        overrange;
`ifdef AMP_METER_DC_EN
  logic [11:0] dc_code;
  modport master (output adc_valid, adc_data, gain_idx, gain_stable,
                  input meas_valid, vpp_code, vin_mv, meas_gain, overrange, dc_code);
  modport slave (input adc_valid, adc_data, gain_idx, gain_stable,
                 output meas_valid, vpp_code, vin_mv, meas_gain, overrange, dc_code);
`else
  modport master (output adc_valid, adc_data, gain_idx, gain_stable,
                  input meas_valid, vpp_code, vin_mv, meas_gain, overrange);
  modport slave (input adc_valid, adc_data, gain_idx, gain_stable,
                 output meas_valid, vpp_code, vin_mv, meas_gain, overrange);
`endif
endinterface

// File: rtl/amplitude_meter_gain_scale.sv
// gain_scale: registered ADC-code to input-referred mV conversion with round-half-up
module gain_scale
  import amp_meter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] code,
  input  logic [1:0]  gain,
  output logic [11:0] mv
);
  // 28-bit product plus half LSB of the 16-bit fraction, keep the integer mV part
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mv <= '0;
    else mv <= 12'(({16'd0, code} * {12'd0, k_of(gain)} + 28'd32768) >> 16);
endmodule

// File: rtl/amplitude_meter.sv
// amplitude_meter: windowed peak-to-peak meter with averaging and mV conversion; AMP_METER_DC_EN adds dc_code
module amplitude_meter
  import amp_meter_pkg::*;
#(
  parameter int WINDOW_LOG2 = 9,
  parameter int AVG_LOG2    = 2,
  parameter int OVER_THRESH = OVER_THRESH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  amplitude_meter_if.slave  bus
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int WC = AVG_LOG2 + 1;
  localparam logic [WC-1:0] LAST_WIN = WC'((1 << AVG_LOG2) - 1);
  localparam logic [11:0] THR = 12'(OVER_THRESH);
  state_t                 state;
  logic [1:0]             gain_q;
  logic [11:0]            peak, valley, npk, nvl, mean, mv;
  logic [WINDOW_LOG2-1:0] sample_cnt;
  logic [WC-1:0]          win_cnt;
  logic [AW-1:0]          vpp_acc, acc_nxt;
  logic                   ovr_q, abort, win_end;
  assign npk     = bus.adc_data > peak ? bus.adc_data : peak;
  assign nvl     = bus.adc_data < valley ? bus.adc_data : valley;
  assign acc_nxt = vpp_acc + AW'(npk - nvl);
  assign mean    = 12'(vpp_acc >> AVG_LOG2);
  assign abort   = !bus.gain_stable || bus.gain_idx != gain_q;
  assign win_end = &sample_cnt;
  gain_scale u_scale (.clk(clk), .rst_n(rst_n), .code(mean), .gain(gain_q), .mv(mv));
  // measurement FSM: arm on stable gain, collect windows, scale, publish, re-arm
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      gain_q         <= '0;
      peak           <= '0;
      valley         <= 12'hFFF;
      sample_cnt     <= '0;
      win_cnt        <= '0;
      vpp_acc        <= '0;
      ovr_q          <= 1'b0;
      bus.meas_valid <= 1'b0;
      bus.vpp_code   <= '0;
      bus.vin_mv     <= '0;
      bus.meas_gain  <= '0;
      bus.overrange  <= 1'b0;
    end else begin
      bus.meas_valid <= 1'b0;
      case (state)
        IDLE: if (bus.gain_stable) begin
          gain_q     <= bus.gain_idx;
          peak       <= '0;
          valley     <= 12'hFFF;
          sample_cnt <= '0;
          win_cnt    <= '0;
          vpp_acc    <= '0;
          ovr_q      <= 1'b0;
          state      <= ACQUIRE;
        end
        ACQUIRE: if (abort) begin
          ovr_q <= 1'b0;
          state <= IDLE;
        end else if (bus.adc_valid) begin
          ovr_q      <= ovr_q | (bus.adc_data >= THR);
          sample_cnt <= sample_cnt + WINDOW_LOG2'(1);
          if (win_end) begin
            vpp_acc <= acc_nxt;
            win_cnt <= win_cnt + WC'(1);
            peak    <= '0;
            valley  <= 12'hFFF;
            if (win_cnt == LAST_WIN) state <= CALC;
          end else begin
            peak   <= npk;
            valley <= nvl;
          end
        end
        CALC: state <= OUTPUT;
        default: begin
          bus.meas_valid <= 1'b1;
          bus.vpp_code   <= mean;
          bus.vin_mv     <= mv;
          bus.meas_gain  <= gain_q;
          bus.overrange  <= ovr_q;
          peak           <= '0;
          valley         <= 12'hFFF;
          sample_cnt     <= '0;
          win_cnt        <= '0;
          vpp_acc        <= '0;
          ovr_q          <= 1'b0;
          state          <= abort ? IDLE : ACQUIRE;
        end
      endcase
    end
`ifdef AMP_METER_DC_EN
  localparam int DW = 12 + WINDOW_LOG2;
  logic [DW-1:0] dc_acc, dc_nxt;
  logic [11:0]   dc_last;
  assign dc_nxt = dc_acc + DW'(bus.adc_data);
  // per-window sample sum; the mean of the last completed window is published with the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dc_acc      <= '0;
      dc_last     <= '0;
      bus.dc_code <= '0;
    end else begin
      if (state == ACQUIRE && !abort && bus.adc_valid) begin
        dc_acc <= win_end ? '0 : dc_nxt;
        if (win_end) dc_last <= 12'(dc_nxt >> WINDOW_LOG2);
      end else if (state != ACQUIRE) dc_acc <= '0;
      if (state == OUTPUT) bus.dc_code <= dc_last;
    end
`endif
endmodule
